// File: rtl/fir_sequencer_if.sv
// Core-side bus of the FIR sequencer: sample intake, result return,
// coefficient load and status.
//   slave  : the sequencer (consumes samples/coefficients, produces results)
//   master : the core/driver side
interface fir_sequencer_if #(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    logic                  accelerateEn;
    logic                  flush;
    logic                  coefWe;
    logic [ADDR_W-1:0]     coefAddr;
    logic [DATA_WIDTH-1:0] coefData;
    logic                  sampleValid;
    logic                  sampleReady;
    logic [DATA_WIDTH-1:0] sampleIn;
    logic                  resultValid;
    logic                  resultReady;
    logic [DATA_WIDTH-1:0] resultOut;
    logic                  busy;
    logic                  wrErr;

    modport master (
        output accelerateEn, flush, coefWe, coefAddr, coefData,
               sampleValid, sampleIn, resultReady,
        input  sampleReady, resultValid, resultOut, busy, wrErr
    );

    modport slave (
        input  accelerateEn, flush, coefWe, coefAddr, coefData,
               sampleValid, sampleIn, resultReady,
        output sampleReady, resultValid, resultOut, busy, wrErr
    );
endinterface

// File: rtl/fir_sequencer.sv
// Time-multiplexed FIR controller: coefficient bank, circular delay line and
// one shared signed MAC stepped over all taps, one tap per cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - fir_sequencer_if.slave: sample in (valid/ready), result out
//          (valid/ready), coefficient write port, flush, busy, wrErr
module fir_sequencer #(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHIFT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    fir_sequencer_if.slave   bus
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned ACC_W  = PROD_W + ADDR_W;

    localparam logic [ADDR_W:0]        NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0]      LAST_TAP   = ADDR_W'(NUM_REGS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        ACC_W'($signed({1'b0, {(DATA_WIDTH-1){1'b1}}}));
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        ACC_W'($signed({1'b1, {(DATA_WIDTH-1){1'b0}}}));

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_ROUND   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DATA_WIDTH-1:0] r_coef  [NUM_REGS];
    logic signed [DATA_WIDTH-1:0] r_delay [NUM_REGS];
    logic [ADDR_W-1:0]            r_head;
    logic [ADDR_W-1:0]            r_base;
    logic [ADDR_W-1:0]            r_tap;
    logic signed [ACC_W-1:0]      r_acc;
    logic [DATA_WIDTH-1:0]        r_result;
    logic                         r_result_valid;
    logic                         r_wr_err;

    logic                         w_sample_ready;
    logic                         w_flush;
    logic                         w_accept;
    logic                         w_last_tap;
    logic                         w_res_hs;
    logic                         w_coef_ok;
    logic [ADDR_W-1:0]            w_tap_idx;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [ACC_W-1:0]      w_shifted;
    logic [DATA_WIDTH-1:0]        w_sat;

    // Ready is forced low while reset is asserted so every output reads 0.
    assign w_sample_ready = rst && (r_state == S_IDLE) && bus.accelerateEn;
    // Flush wins over a simultaneous handshake.
    assign w_flush    = (r_state == S_IDLE) && bus.flush;
    assign w_accept   = w_sample_ready && bus.sampleValid && !bus.flush;
    assign w_last_tap = (r_tap == LAST_TAP);
    assign w_res_hs   = (r_state == S_DONE) && r_result_valid && bus.resultReady;
    assign w_coef_ok  = (r_state == S_IDLE) && ({1'b0, bus.coefAddr} < NUM_REGS_W);

    // Tap k pairs with the sample k steps older than the newest; wraps mod NUM_REGS.
    assign w_tap_idx = r_base - r_tap;
    assign w_prod    = PROD_W'(r_coef[r_tap]) * PROD_W'(r_delay[w_tap_idx]);
    assign w_shifted = r_acc >>> SHIFT;

    // Clamp the shifted accumulator into the signed result range.
    always_comb begin
        w_sat = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept)   w_state_nxt = S_COMPUTE;
            S_COMPUTE: if (w_last_tap) w_state_nxt = S_ROUND;
            S_ROUND:                   w_state_nxt = S_DONE;
            S_DONE:    if (w_res_hs)   w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: delay line, MAC, result register and coefficient bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_coef[i]  <= '0;
                r_delay[i] <= '0;
            end
            r_head         <= '0;
            r_base         <= '0;
            r_tap          <= '0;
            r_acc          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_wr_err       <= 1'b0;
        end else begin
            if (w_flush) begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    r_delay[i] <= '0;
                end
                r_head <= '0;
            end else if (w_accept) begin
                r_delay[r_head] <= bus.sampleIn;
                r_base          <= r_head;
                r_head          <= r_head + ADDR_W'(1);
                r_acc           <= '0;
                r_tap           <= '0;
            end

            if (r_state == S_COMPUTE) begin
                r_acc <= r_acc + ACC_W'(w_prod);
                r_tap <= r_tap + ADDR_W'(1);
            end

            if (r_state == S_ROUND) begin
                r_result       <= w_sat;
                r_result_valid <= 1'b1;
            end

            if (w_res_hs) begin
                r_result_valid <= 1'b0;
            end

            // Writes outside IDLE or out of range are dropped and latched as an error.
            if (bus.coefWe) begin
                if (w_coef_ok) begin
                    r_coef[bus.coefAddr] <= bus.coefData;
                end else begin
                    r_wr_err <= 1'b1;
                end
            end
        end
    end

    assign bus.sampleReady = w_sample_ready;
    assign bus.resultValid = r_result_valid;
    assign bus.resultOut   = r_result;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.wrErr       = r_wr_err;

endmodule

// File: tb/tb_fir_sequencer.sv
// Scoreboard bench for fir_sequencer: a behavioural FIR model predicts each
// result when the sample is driven; a monitor pops and compares on every
// result handshake and checks accept-to-valid latency.
module tb_fir_sequencer;
    localparam int unsigned N     = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = $clog2(N);
    localparam int unsigned CLK_P = 10;
    localparam int unsigned LAT   = N + 1;

    localparam logic signed [66:0] M_MAX = 67'sd2147483647;
    localparam logic signed [66:0] M_MIN = -67'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    always #(CLK_P/2) clk = ~clk;

    fir_sequencer_if #(.NUM_REGS(N), .DATA_WIDTH(DW)) bus_a ();
    fir_sequencer_if #(.NUM_REGS(N), .DATA_WIDTH(DW)) bus_b ();

    fir_sequencer #(.NUM_REGS(N), .DATA_WIDTH(DW), .SHIFT(0)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    fir_sequencer #(.NUM_REGS(N), .DATA_WIDTH(DW), .SHIFT(2)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sb_q[$];
    time         lat_q[$];
    logic        prev_valid = 1'b0;

    logic signed [31:0] m_coef  [N];
    logic signed [31:0] m_delay [N];
    int                 m_head;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < int'(N); i++) begin
            m_coef[i]  = '0;
            m_delay[i] = '0;
        end
        m_head = 0;
    endfunction

    // Behavioural FIR: insert sample, form full-precision sum, shift 0, saturate.
    function automatic logic [31:0] model_push(input logic [31:0] s);
        logic signed [66:0] acc;
        int                 base;
        m_delay[m_head] = s;
        base   = m_head;
        m_head = (m_head + 1) % int'(N);
        acc    = '0;
        for (int k = 0; k < int'(N); k++) begin
            acc = acc + 67'(m_coef[k]) * 67'(m_delay[(base - k + int'(N)) % int'(N)]);
        end
        if (acc > M_MAX) return 32'h7FFF_FFFF;
        if (acc < M_MIN) return 32'h8000_0000;
        return acc[31:0];
    endfunction

    // Result monitor for DUT A.
    always @(negedge clk) begin
        if (rst) begin
            if (bus_a.resultValid && !prev_valid) begin
                if (lat_q.size() > 0) begin
                    time t_acc;
                    t_acc = lat_q.pop_front();
                    check_eq("latency", 32'(($time - t_acc) / CLK_P), 32'(LAT));
                end else begin
                    check_eq("unexpected_valid", 32'(1), 32'(0));
                end
            end
            if (bus_a.resultValid && bus_a.resultReady) begin
                if (sb_q.size() > 0) begin
                    logic [31:0] e;
                    e = sb_q.pop_front();
                    check_eq("result", bus_a.resultOut, e);
                end else begin
                    check_eq("sb_underflow", 32'(1), 32'(0));
                end
            end
        end
        prev_valid = bus_a.resultValid;
    end

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(bus_a.resultValid), 32'(0));
        check_eq({tag, "_out"},   bus_a.resultOut,        32'(0));
        check_eq({tag, "_busy"},  32'(bus_a.busy),        32'(0));
        check_eq({tag, "_wrerr"}, 32'(bus_a.wrErr),       32'(0));
        check_eq({tag, "_ready"}, 32'(bus_a.sampleReady), 32'(0));
    endtask

    task automatic write_coef(input int a, input logic [31:0] d);
        bus_a.coefWe   = 1'b1;
        bus_a.coefAddr = AW'(a);
        bus_a.coefData = d;
        @(posedge clk);
        #1;
        bus_a.coefWe = 1'b0;
        m_coef[a] = d;
    endtask

    // Drive one sample, push its prediction, return at accept edge + 1.
    task automatic send(input logic [31:0] s);
        int   n;
        logic got;
        sb_q.push_back(model_push(s));
        bus_a.sampleIn    = s;
        bus_a.sampleValid = 1'b1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            if (bus_a.sampleReady) got = 1'b1;
            n++;
        end
        if (got) begin
            @(posedge clk);
            lat_q.push_back($time);
            #1;
        end else begin
            check_eq("accept_timeout", 32'(0), 32'(1));
            void'(sb_q.pop_back());
        end
        bus_a.sampleValid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int   n;
        logic done;
        done = 1'b0;
        n    = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !bus_a.busy) done = 1'b1;
            n++;
        end
        if (!done) check_eq({tag, "_drain_timeout"}, 32'(0), 32'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #(CLK_P * 20000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        int          n;

        rst = 1'b0;
        bus_a.accelerateEn = 1'b1; bus_b.accelerateEn = 1'b1;
        bus_a.flush = 1'b0;        bus_b.flush = 1'b0;
        bus_a.coefWe = 1'b0;       bus_b.coefWe = 1'b0;
        bus_a.coefAddr = '0;       bus_b.coefAddr = '0;
        bus_a.coefData = '0;       bus_b.coefData = '0;
        bus_a.sampleValid = 1'b0;  bus_b.sampleValid = 1'b0;
        bus_a.sampleIn = '0;       bus_b.sampleIn = '0;
        bus_a.resultReady = 1'b1;  bus_b.resultReady = 1'b1;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Impulse response with coef[k] = k+1.
        for (int k = 0; k < int'(N); k++) write_coef(k, 32'(k + 1));
        for (int i = 0; i <= int'(N); i++) send((i == 0) ? 32'd1 : 32'd0);
        wait_drain("impulse");
        check_eq("impulse_wrerr", 32'(bus_a.wrErr), 32'(0));

        // Positive then negative saturation.
        for (int k = 0; k < int'(N); k++) write_coef(k, 32'h7FFF_FFFF);
        for (int i = 0; i < int'(N); i++) send(32'h7FFF_FFFF);
        wait_drain("sat_pos");
        for (int i = 0; i < int'(N); i++) send(32'h8000_0001);
        wait_drain("sat_neg");

        // Backpressure: result held stable while resultReady is low.
        for (int k = 0; k < int'(N); k++) write_coef(k, 32'(k + 1));
        bus_a.resultReady = 1'b0;
        send(32'd3);
        n = 0;
        while (!bus_a.resultValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_valid_rise", 32'(bus_a.resultValid), 32'(1));
        held = bus_a.resultOut;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(bus_a.resultValid), 32'(1));
            check_eq("bp_out",   bus_a.resultOut,        held);
            check_eq("bp_ready", 32'(bus_a.sampleReady), 32'(0));
            check_eq("bp_busy",  32'(bus_a.busy),        32'(1));
        end
        @(posedge clk);
        #1;
        bus_a.resultReady = 1'b1;
        @(posedge clk);
        #1;
        bus_a.resultReady = 1'b0;
        check_eq("bp_idle_busy",  32'(bus_a.busy),        32'(0));
        check_eq("bp_idle_valid", 32'(bus_a.resultValid), 32'(0));
        bus_a.resultReady = 1'b1;
        wait_drain("bp");

        // Coefficient write during COMPUTE is dropped and flagged.
        send(32'd2);
        bus_a.coefWe   = 1'b1;
        bus_a.coefAddr = '0;
        bus_a.coefData = 32'h55;
        @(posedge clk);
        #1;
        bus_a.coefWe = 1'b0;
        check_eq("prot_wrerr", 32'(bus_a.wrErr), 32'(1));
        wait_drain("prot_cur");
        send(32'd7);
        wait_drain("prot_bank");
        write_coef(0, 32'd1);
        check_eq("prot_wrerr_sticky", 32'(bus_a.wrErr), 32'(1));

        // Asynchronous reset in the middle of a computation.
        send(32'd9);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_zero_outputs("midrst");
        sb_q.delete();
        lat_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) send((i == 0) ? 32'd1 : 32'd0);
        wait_drain("post_rst");

        // Flush: wins over a simultaneous sample, then restarts at head 0.
        for (int k = 0; k < int'(N); k++) write_coef(k, 32'd1);
        for (int i = 0; i < int'(N); i++) send(32'd5);
        wait_drain("fill");
        bus_a.flush       = 1'b1;
        bus_a.sampleIn    = 32'd7;
        bus_a.sampleValid = 1'b1;
        @(posedge clk);
        #1;
        bus_a.flush       = 1'b0;
        bus_a.sampleValid = 1'b0;
        check_eq("flush_no_accept", 32'(bus_a.busy), 32'(0));
        for (int i = 0; i < int'(N); i++) m_delay[i] = '0;
        m_head = 0;
        send(32'd1);
        wait_drain("flush");

        // accelerateEn low blocks acceptance.
        bus_a.accelerateEn = 1'b0;
        bus_a.sampleIn     = 32'd4;
        bus_a.sampleValid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("en_ready", 32'(bus_a.sampleReady), 32'(0));
            check_eq("en_busy",  32'(bus_a.busy),        32'(0));
        end
        @(posedge clk);
        #1;
        bus_a.sampleValid  = 1'b0;
        bus_a.accelerateEn = 1'b1;

        // SHIFT = 2 instance: 4 * 12 >>> 2 = 12.
        bus_b.coefWe   = 1'b1;
        bus_b.coefAddr = '0;
        bus_b.coefData = 32'd4;
        @(posedge clk);
        #1;
        bus_b.coefWe      = 1'b0;
        bus_b.sampleIn    = 32'd12;
        bus_b.sampleValid = 1'b1;
        n = 0;
        while (!bus_b.sampleReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus_b.sampleValid = 1'b0;
        n = 0;
        while (!bus_b.resultValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("shift2_valid",  32'(bus_b.resultValid), 32'(1));
        check_eq("shift2_result", bus_b.resultOut,        32'd12);
        @(posedge clk);
        #1;
        check_eq("shift2_idle", 32'(bus_b.busy), 32'(0));

        wait_drain("final");
        check_eq("sb_empty",  32'(sb_q.size()),  32'(0));
        check_eq("lat_empty", 32'(lat_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

Time-multiplexed FIR controller for the CV32E40X FIR accelerator. Holds the coefficient bank and a circular sample delay line. Accepts one raw sensor sample per valid/ready handshake and sequences a single shared signed multiply-accumulate across all NUM_REGS taps, one tap per cycle. Returns a shifted, saturated result over a valid/ready handshake to the core-side interface.

## Interface
- NUM_REGS, 8: number of taps; power of two, at least 2.
- DATA_WIDTH, 32: sample, coefficient and result width; signed two's complement.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation; range 0 to 2*DATA_WIDTH-1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- accelerateEn  in  1  enables sample acceptance.
- flush  in  1  zeroes the delay line and head pointer; honoured in IDLE only.
- coefWe  in  1  coefficient write strobe.
- coefAddr  in  clog2(NUM_REGS)  coefficient index (tap k).
- coefData  in  DATA_WIDTH  coefficient value.
- sampleValid  in  1  sampleIn is valid.
- sampleReady  out  1  block can accept a sample.
- sampleIn  in  DATA_WIDTH  raw sensor sample.
- resultValid  out  1  resultOut is valid.
- resultReady  in  1  consumer accepts the result.
- resultOut  out  DATA_WIDTH  filtered output y[n].
- busy  out  1  state is not IDLE.
- wrErr  out  1  sticky flag: a coefficient write was dropped.

## Operation
- States: IDLE, COMPUTE, ROUND, DONE.
- IDLE:
  - sampleReady = accelerateEn.
  - On sampleValid && sampleReady:
    - write sampleIn to delay[head];
    - latch base = head;
    - advance head = (head+1) mod NUM_REGS;
    - clear acc;
    - set tapIdx = 0;
    - go to COMPUTE.
  - flush has priority over the handshake when both are asserted in the same cycle. No sample is accepted that cycle.
- COMPUTE, on each cycle:
  - acc += coef[tapIdx] * delay[(base - tapIdx) mod NUM_REGS];
  - tapIdx increments;
  - after the tap NUM_REGS-1 update, go to ROUND.
- ROUND: register resultOut = sat(acc >>> SHIFT), set resultValid = 1, go to DONE.
- DONE:
  - Hold resultOut and resultValid stable until resultReady.
  - On resultValid && resultReady: clear resultValid and go to IDLE.
- Arithmetic:
  - Product is 2*DATA_WIDTH signed.
  - acc is 2*DATA_WIDTH + clog2(NUM_REGS) bits signed, so it cannot overflow.
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Delay indexing wraps modulo NUM_REGS. Samples older than NUM_REGS-1 are overwritten.
- Coefficient writes:
  - Accepted only in IDLE with coefAddr < NUM_REGS.
  - Any other write is dropped and sets wrErr.
  - wrErr clears only on reset.
- accelerateEn deasserted outside IDLE has no effect: the current sample completes and its result is delivered.
- Reset (rst = 0, any time, including mid-COMPUTE):
  - state = IDLE;
  - all outputs = 0;
  - acc, head, tapIdx = 0;
  - delay line and coefficient bank zeroed;
  - any in-flight result is discarded.

## Timing
- Accept edge T: the edge on which sampleValid && sampleReady is sampled high.
- COMPUTE updates occur on edges T+1 through T+NUM_REGS.
- The ROUND register update occurs on edge T+NUM_REGS+1. resultValid is high in the following cycle.
- Latency from accept edge to resultValid: NUM_REGS+1 cycles.
- sampleReady is low from edge T until the state returns to IDLE.
- With resultReady held high, the minimum sample interval is NUM_REGS+3 cycles.
- busy rises on edge T and falls on the edge that completes the result handshake.
- flush takes effect on the sampled edge. The next accept uses head = 0.
- A coefficient written in IDLE on edge E is used by a sample accepted on edge E+1 or later.

## Test plan
- Impulse response:
  - Setup: coef[k] = k+1, SHIFT = 0.
  - Stimulus: samples 1,0,0,0,0,0,0,0,0.
  - Required: resultOut = 1,2,3,4,5,6,7,8,0.
  - Required: each result appears exactly 9 cycles after its accept edge.
- Saturation:
  - Setup: all coef = 0x7FFFFFFF.
  - Stimulus: eight samples of 0x7FFFFFFF.
  - Required: the eighth result is 0x7FFFFFFF.
  - Repeat with samples of 0x80000001: required result 0x80000000.
  - Setup: coef[0] = 4, SHIFT = 2. Stimulus: sample 12. Required result: 12.
- Backpressure:
  - Stimulus: hold resultReady = 0 for 20 cycles after resultValid rises.
  - Required: resultOut and resultValid stay stable, sampleReady = 0, busy = 1.
  - Then pulse resultReady for one cycle: required IDLE on the next edge.
- Coefficient protection:
  - Stimulus: coefWe during COMPUTE with coefData = 0x55.
  - Required: bank unchanged, wrErr = 1, current result unaffected.
  - Stimulus: coefAddr ≥ NUM_REGS with NUM_REGS non-power-of-two excluded. Required: wrErr remains sticky.
- Reset mid-operation:
  - Stimulus: assert rst = 0 on cycle T+3 of a computation.
  - Required: all outputs 0 immediately (asynchronous).
  - Required: after release, the impulse test reproduces 0 until coefficients are reloaded.
- Flush and enable:
  - Setup: fill the delay line with 5s.
  - Stimulus: flush in IDLE, then a sample of 1 with coef[k] = 1.
  - Required: result 1.
  - Stimulus: accelerateEn = 0 with sampleValid = 1. Required: sampleReady = 0 and no accept.
